// File: rtl/count_sched_pkg.sv
// count_sched_pkg -- shared types and defaults for the count_sched block.
//   state_t   : scheduler FSM state (IDLE, RUN, DONE)
//   DEF_NREQ  : default number of requesters
//   DEF_CW    : default counter / duration width
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 4;

endpackage

// File: rtl/count_sched_rr.sv
// rr_pick -- combinational round-robin selector.
// Searches req starting at index ptr and wrapping; the first set bit wins.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  PW    index with highest priority for this search
//   onehot out NREQ  one-hot winner (all zero when no request)
//   idx    out PW    winner index (0 when no request)
//   valid  out 1     at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    // Outer loop walks priority distance from ptr, inner loop finds the
    // requester at that distance; the first hit locks out the rest.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    valid     = 1'b1;
                    onehot[i] = 1'b1;
                    idx       = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/count_sched.sv
// count_sched -- round-robin time-slot scheduler for one shared down counter.
// Optional feature macro: COUNT_SCHED_ABORT_EN (dropping req mid-slot aborts it).
// Ports:
//   clk       in  1        rising-edge clock
//   reset     in  1        synchronous active-low reset
//   req       in  NREQ     per-requester request level
//   dur       in  NREQ*CW  per-requester duration, slice i = dur[i*CW +: CW]
//   grant     out NREQ     one-hot current owner, zero when idle
//   count     out CW       remaining cycles of the current slot
//   busy      out 1        grant is nonzero
//   done      out NREQ     one-cycle completion pulse on owner's bit
//   abort     out NREQ     one-cycle abort pulse on owner's bit (0 without macro)
//   state_dbg out 2        current FSM state, for observation only
//
// Handshake: a requester raises req[i] and holds it; grant[i] rises one cycle
// after req[i] is sampled in IDLE and stays high through the DONE cycle, where
// done[i] pulses. The requester may drop req[i] in the cycle after done[i]
// (or abort[i]); dur[i] is sampled only on the granting edge.
import count_sched_pkg::*;

module count_sched #(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] dur,
    output logic [NREQ-1:0]    grant,
    output logic [CW-1:0]      count,
    output logic               busy,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    abort,
    output logic [1:0]         state_dbg
);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [CW-1:0]     count_q, count_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   abort_q, abort_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     w_q, w_d;

    logic [NREQ-1:0]   pick_oh;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [CW-1:0]     dur_sel;
    logic [PW-1:0]     next_ptr;
    logic              abort_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Duration of the requester that would win this cycle.
    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) dur_sel = dur[i*CW +: CW];
        end
    end

    assign next_ptr = (w_q == PW'(NREQ - 1)) ? '0 : w_q + PW'(1);

`ifdef COUNT_SCHED_ABORT_EN
    // Owner released its request while its slot is still running.
    assign abort_hit = ~|(req & grant_q);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
        done_d  = '0;
        abort_d = '0;
        ptr_d   = ptr_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                count_d = '0;
                if (pick_valid) begin
                    grant_d = pick_oh;
                    count_d = dur_sel;
                    w_d     = pick_idx;
                    if (dur_sel != '0) begin
                        state_d = RUN;
                    end else begin
                        // Zero-length slot: grant and done share one cycle.
                        state_d = DONE;
                        done_d  = pick_oh;
                    end
                end
            end
            RUN: begin
                if (abort_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                    abort_d = grant_q;
                    ptr_d   = next_ptr;
                end else if (count_q <= CW'(1)) begin
                    state_d = DONE;
                    count_d = '0;
                    done_d  = grant_q;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            abort_q <= '0;
            ptr_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
        end
    end

    assign grant     = grant_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched -- self-checking bench for count_sched (NREQ=4, CW=4).
// Each slot is predicted as a whole transaction: winner from the request
// vector and a round-robin pointer, then dur+1 granted cycles with count
// dur..0, done on the last, followed by one idle cycle.
module tb_count_sched;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] dur;
    logic [NREQ-1:0]    grant;
    logic [CW-1:0]      count;
    logic               busy;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    abort;
    logic [1:0]         state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = 0;
    logic [CW-1:0] exp_q[$];

    count_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dur       (dur),
        .grant     (grant),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference arbitration: first requester at or after p, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Called at a negedge inside an idle cycle. Drives one request pattern,
    // checks the complete slot and the trailing idle cycle.
    task automatic run_slot(input logic [3:0] r, input logic [15:0] dv, input bit jitter,
                            output int w, output logic [3:0] g_first);
        logic [3:0] oh;
        int d;
        req = r;
        dur = dv;
        w   = pick(r, model_ptr);
        oh  = 4'(4'b0001 << w);
        d   = int'(dv[w*4 +: 4]);
        for (int k = d; k >= 0; k--) exp_q.push_back(4'(k));
        @(posedge clk);
        g_first = 4'b0;
        for (int k = 0; k <= d; k++) begin
            @(negedge clk);
            if (k == 0) g_first = grant;
            chk("slot_grant", 32'(grant), 32'(oh));
            chk("slot_count", 32'(count), 32'(exp_q.pop_front()));
            chk("slot_busy",  32'(busy),  32'd1);
            chk("slot_done",  32'(done),  32'((k == d) ? oh : 4'b0));
            chk("slot_abort", 32'(abort), 32'd0);
            if (jitter) begin
                req = 4'($urandom_range(0, 15)) | oh;
                dur = 16'($urandom);
            end
        end
        @(negedge clk);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_done",  32'(done),  32'd0);
        chk("idle_busy",  32'(busy),  32'd0);
        model_ptr = (w + 1) % 4;
    endtask

    initial begin
        int w;
        logic [3:0] g;
        logic [15:0] dv;
        int rr_order[6] = '{0, 1, 3, 0, 1, 3};

        // reset held with all requests high
        reset = 1'b0;
        req   = 4'b1111;
        dur   = 16'h0002;
        repeat (3) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_busy",  32'(busy),  32'd0);
            chk("rst_done",  32'(done),  32'd0);
            chk("rst_abort", 32'(abort), 32'd0);
        end
        reset = 1'b1;
        model_ptr = 0;
        run_slot(4'b1111, 16'h0002, 1'b0, w, g);
        chk("first_grant", 32'(g), 32'h1);

        // single slot: requester 2, duration 3
        run_slot(4'b0100, 16'h0300, 1'b0, w, g);
        chk("single_grant", 32'(g), 32'h4);

        // zero duration: requester 1
        run_slot(4'b0010, 16'h0000, 1'b0, w, g);
        chk("zero_grant", 32'(g), 32'h2);

        // reset in the middle of a 15-cycle slot
        req = 4'b0001;
        dur = 16'h000F;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("mr_count", 32'(count), 32'(15 - k));
            chk("mr_grant", 32'(grant), 32'h1);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mr_rst_grant", 32'(grant), 32'd0);
        chk("mr_rst_count", 32'(count), 32'd0);
        chk("mr_rst_done",  32'(done),  32'd0);
        chk("mr_rst_busy",  32'(busy),  32'd0);
        reset = 1'b1;
        req   = 4'b0000;
        model_ptr = 0;
        @(negedge clk);
        chk("mr_post_done",  32'(done),  32'd0);
        chk("mr_post_grant", 32'(grant), 32'd0);

        // round robin over requesters 0,1,3 starting from a fresh pointer
        for (int i = 0; i < 6; i++) begin
            run_slot(4'b1011, 16'h1111, 1'b0, w, g);
            chk("rr_order", 32'(g), 32'(4'(4'b0001 << rr_order[i])));
        end

        // requester 3 drops its request while count is 6
        req = 4'b1000;
        dur = 16'hA000;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("ab_count", 32'(count), 32'(10 - k));
            chk("ab_grant", 32'(grant), 32'h8);
            if (k == 4) req = 4'b0000;
        end
`ifdef COUNT_SCHED_ABORT_EN
        @(negedge clk);
        chk("ab_abort", 32'(abort), 32'h8);
        chk("ab_grant0", 32'(grant), 32'd0);
        chk("ab_count0", 32'(count), 32'd0);
        chk("ab_nodone", 32'(done), 32'd0);
        chk("ab_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        chk("ab_abort_clr", 32'(abort), 32'd0);
        chk("ab_idle_grant", 32'(grant), 32'd0);
`else
        for (int k = 5; k <= 10; k++) begin
            @(negedge clk);
            chk("ab_count", 32'(count), 32'(10 - k));
            chk("ab_grant", 32'(grant), 32'h8);
            chk("ab_done",  32'(done),  32'((k == 10) ? 4'h8 : 4'h0));
            chk("ab_abort", 32'(abort), 32'd0);
        end
        @(negedge clk);
        chk("ab_idle_grant", 32'(grant), 32'd0);
        chk("ab_idle_done",  32'(done),  32'd0);
`endif
        model_ptr = 0;

        // randomized slots; non-owner requests and durations jitter mid-slot
        repeat (40) begin
            for (int i = 0; i < 4; i++) begin
                dv[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                            : 4'($urandom_range(0, 3));
            end
            run_slot(4'($urandom_range(1, 15)), dv, 1'b1, w, g);
        end
        req = 4'b0000;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
